// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller and its scoreboard.
//   FWD_REG / FWD_E / FWD_M : forwarding select encodings (3 is never produced)
//   fwd_sel_t               : one forwarding select
//   REG_W_DEF               : default register index width (int + float file)
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W_DEF = 6;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'd0;
    localparam fwd_sel_t FWD_E   = 2'd1;
    localparam fwd_sel_t FWD_M   = 2'd2;

endpackage : pipe_pkg

// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
// Tracks destinations of long-latency ops (fdiv/fsqrt) that are in flight.
//   clk, rstn      : clock, asynchronous active-low reset
//   i_issue        : a long op leaves decode this cycle
//   i_issue_rd     : its destination register
//   i_done         : long unit writes back this cycle
//   i_done_rd      : destination being written back
//   o_busy         : one busy bit per architectural register
//   o_full         : MAX_LONG ops are outstanding
// ---------------------------------------------------------------------------
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int MAX_LONG = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_issue,
    input  logic [REG_W-1:0]      i_issue_rd,
    input  logic                  i_done,
    input  logic [REG_W-1:0]      i_done_rd,
    output logic [2**REG_W-1:0]   o_busy,
    output logic                  o_full
);

    localparam int CNT_W = $clog2(MAX_LONG + 1);

    logic [2**REG_W-1:0] r_busy;
    logic [2**REG_W-1:0] w_busy_next;
    logic [CNT_W-1:0]    r_outstanding;
    logic [CNT_W-1:0]    w_outstanding_next;
    logic                w_done_ok;
    logic                w_issue_ok;

    // Write-backs to reg 0 or to a register that is not busy (e.g. one
    // whose op was wiped by reset) are stale and must not touch the count.
    assign w_done_ok = i_done && (i_done_rd != '0) && r_busy[i_done_rd];

    // An issue onto a reg that is still busy is only legal when that reg
    // retires in the same cycle; otherwise the count would drift.
    assign w_issue_ok = i_issue && (i_issue_rd != '0) &&
                        (!r_busy[i_issue_rd] ||
                         (w_done_ok && (i_done_rd == i_issue_rd)));

    always_comb begin
        w_busy_next        = r_busy;
        w_outstanding_next = r_outstanding;
        // Clear before set: same-reg done+issue leaves the bit at 1.
        if (w_done_ok) begin
            w_busy_next[i_done_rd] = 1'b0;
        end
        if (w_issue_ok) begin
            w_busy_next[i_issue_rd] = 1'b1;
        end
        if (w_issue_ok && !w_done_ok && !o_full) begin
            w_outstanding_next = r_outstanding + CNT_W'(1);
        end else if (w_done_ok && !w_issue_ok && (r_outstanding != '0)) begin
            w_outstanding_next = r_outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy        <= '0;
            r_outstanding <= '0;
        end else begin
            r_busy        <= w_busy_next;
            r_outstanding <= w_outstanding_next;
        end
    end

    assign o_busy = r_busy;
    assign o_full = (r_outstanding == CNT_W'(MAX_LONG));

endmodule : pipe_scoreboard

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard unit for the 5-stage core: operand forwarding, load-use and
// long-op scoreboard stalls, branch flushes, stage enables, perf counters.
//   clk, rstn                      : clock, asynchronous active-low reset
//   d_valid/d_rs/d_rs_used/d_rd/d_regwrite/d_long : decode instruction info
//   e_valid/e_rd/e_regwrite/e_memread              : exec stage destination
//   m_valid/m_rd/m_regwrite                        : memory stage destination
//   exec_fin, memory_fin           : stage not busy
//   branchjump_miss                : mispredict resolved in exec
//   lw_done, lw_rd                 : long unit write-back
//   fwd_sel                        : per-source forwarding select
//   stall_d                        : decode held
//   fetch_en..write_en             : pipeline register enables
//   decode_flush, exec_flush       : bubble insertion
//   sb_busy                        : scoreboard busy bits
//   stall_cnt, flush_cnt           : saturating perf counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int NSRC     = 3,
    parameter int MAX_LONG = 4,
    parameter int PERF_W   = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    d_valid,
    input  logic [NSRC*REG_W-1:0]   d_rs,
    input  logic [NSRC-1:0]         d_rs_used,
    input  logic [REG_W-1:0]        d_rd,
    input  logic                    d_regwrite,
    input  logic                    d_long,
    input  logic                    e_valid,
    input  logic [REG_W-1:0]        e_rd,
    input  logic                    e_regwrite,
    input  logic                    e_memread,
    input  logic                    m_valid,
    input  logic [REG_W-1:0]        m_rd,
    input  logic                    m_regwrite,
    input  logic                    exec_fin,
    input  logic                    memory_fin,
    input  logic                    branchjump_miss,
    input  logic                    lw_done,
    input  logic [REG_W-1:0]        lw_rd,
    output logic [NSRC*2-1:0]       fwd_sel,
    output logic                    stall_d,
    output logic                    fetch_en,
    output logic                    decode_en,
    output logic                    exec_en,
    output logic                    memory_en,
    output logic                    write_en,
    output logic                    decode_flush,
    output logic                    exec_flush,
    output logic [2**REG_W-1:0]     sb_busy,
    output logic [PERF_W-1:0]       stall_cnt,
    output logic [PERF_W-1:0]       flush_cnt
);

    logic [NSRC-1:0] w_lu_hit;
    logic [NSRC-1:0] w_src_busy;
    logic            w_lu_stall;
    logic            w_sb_stall;
    logic            w_sb_full;
    logic            w_go;
    logic            w_adv;
    logic            w_issue;

    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    // Per-source forwarding and hazard detection.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic [REG_W-1:0] w_rs;
            logic             w_chk;
            logic             w_e_hit;
            logic             w_m_hit;

            assign w_rs  = d_rs[gi*REG_W +: REG_W];
            assign w_chk = d_rs_used[gi] && (w_rs != '0);

            // A load in E has no data yet, so it cannot forward; that case
            // is covered by the load-use stall instead.
            assign w_e_hit = w_chk && e_valid && e_regwrite && !e_memread &&
                             (e_rd == w_rs);
            assign w_m_hit = w_chk && m_valid && m_regwrite && (m_rd == w_rs);

            assign fwd_sel[gi*2 +: 2] = w_e_hit ? FWD_E :
                                        w_m_hit ? FWD_M : FWD_REG;

            assign w_lu_hit[gi]   = d_rs_used[gi] && e_valid && e_memread &&
                                    (e_rd != '0) && (e_rd == w_rs);
            assign w_src_busy[gi] = d_rs_used[gi] && sb_busy[w_rs];
        end
    endgenerate

    assign w_lu_stall = |w_lu_hit;
    assign w_sb_stall = d_valid &&
                        ((|w_src_busy) ||
                         (d_regwrite && (d_rd != '0) && sb_busy[d_rd]) ||
                         (d_long && w_sb_full));
    assign stall_d    = w_lu_stall || w_sb_stall;

    // Front end only advances when both back stages are free and nothing
    // needs holding or squashing in decode.
    assign w_go      = exec_fin && memory_fin;
    assign w_adv     = !stall_d && !branchjump_miss && w_go;
    assign fetch_en  = w_adv;
    assign decode_en = w_adv;
    assign exec_en   = w_adv;
    assign memory_en = w_go;
    assign write_en  = memory_fin;

    assign decode_flush = branchjump_miss;
    assign exec_flush   = (branchjump_miss || stall_d) && memory_en;

    // exec_en is already low on a mispredict, so wrong-path long ops never
    // reach the scoreboard.
    assign w_issue = exec_en && d_valid && d_long && d_regwrite && (d_rd != '0);

    pipe_scoreboard #(
        .REG_W    (REG_W),
        .MAX_LONG (MAX_LONG)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .i_issue    (w_issue),
        .i_issue_rd (d_rd),
        .i_done     (lw_done),
        .i_done_rd  (lw_rd),
        .o_busy     (sb_busy),
        .o_full     (w_sb_full)
    );

    // Saturating perf counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (d_valid && stall_d && !branchjump_miss && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (branchjump_miss && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REG_W    = 6;
    localparam int NSRC     = 3;
    localparam int MAX_LONG = 4;
    localparam int PERF_W   = 32;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  d_valid;
    logic [NSRC*REG_W-1:0] d_rs;
    logic [NSRC-1:0]       d_rs_used;
    logic [REG_W-1:0]      d_rd;
    logic                  d_regwrite;
    logic                  d_long;
    logic                  e_valid;
    logic [REG_W-1:0]      e_rd;
    logic                  e_regwrite;
    logic                  e_memread;
    logic                  m_valid;
    logic [REG_W-1:0]      m_rd;
    logic                  m_regwrite;
    logic                  exec_fin;
    logic                  memory_fin;
    logic                  branchjump_miss;
    logic                  lw_done;
    logic [REG_W-1:0]      lw_rd;
    logic [NSRC*2-1:0]     fwd_sel;
    logic                  stall_d;
    logic                  fetch_en;
    logic                  decode_en;
    logic                  exec_en;
    logic                  memory_en;
    logic                  write_en;
    logic                  decode_flush;
    logic                  exec_flush;
    logic [2**REG_W-1:0]   sb_busy;
    logic [PERF_W-1:0]     stall_cnt;
    logic [PERF_W-1:0]     flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W    (REG_W),
        .NSRC     (NSRC),
        .MAX_LONG (MAX_LONG),
        .PERF_W   (PERF_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .d_valid         (d_valid),
        .d_rs            (d_rs),
        .d_rs_used       (d_rs_used),
        .d_rd            (d_rd),
        .d_regwrite      (d_regwrite),
        .d_long          (d_long),
        .e_valid         (e_valid),
        .e_rd            (e_rd),
        .e_regwrite      (e_regwrite),
        .e_memread       (e_memread),
        .m_valid         (m_valid),
        .m_rd            (m_rd),
        .m_regwrite      (m_regwrite),
        .exec_fin        (exec_fin),
        .memory_fin      (memory_fin),
        .branchjump_miss (branchjump_miss),
        .lw_done         (lw_done),
        .lw_rd           (lw_rd),
        .fwd_sel         (fwd_sel),
        .stall_d         (stall_d),
        .fetch_en        (fetch_en),
        .decode_en       (decode_en),
        .exec_en         (exec_en),
        .memory_en       (memory_en),
        .write_en        (write_en),
        .decode_flush    (decode_flush),
        .exec_flush      (exec_flush),
        .sb_busy         (sb_busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic set_idle();
        d_valid = 0; d_rs = '0; d_rs_used = '0; d_rd = '0; d_regwrite = 0; d_long = 0;
        e_valid = 0; e_rd = '0; e_regwrite = 0; e_memread = 0;
        m_valid = 0; m_rd = '0; m_regwrite = 0;
        exec_fin = 1; memory_fin = 1; branchjump_miss = 0; lw_done = 0; lw_rd = '0;
    endtask

    // Drive a decode-stage long op writing rd.
    task automatic drive_long(input logic [REG_W-1:0] rd);
        d_valid = 1; d_long = 1; d_regwrite = 1; d_rd = rd; d_rs_used = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rstn = 0;
        #2;
        rstn = 1;
    endtask

    task automatic test_reset();
        set_idle();
        rstn = 0;
        #1;
        checks++; if (sb_busy !== '0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", sb_busy); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush_cnt !== '0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
        checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL reset_stall_d got=%0b exp=0", stall_d); end
        checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL reset_fetch_en got=%0b exp=1", fetch_en); end
        @(negedge clk);
        rstn = 1;
        $display("test_reset: done");
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        set_idle();
        d_valid = 1; d_rs[0 +: 6] = 6'd5; d_rs_used = 3'b001;
        e_valid = 1; e_regwrite = 1; e_rd = 6'd5;
        m_valid = 1; m_regwrite = 1; m_rd = 6'd5;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd1) begin failures++; $display("FAIL fwd_e_prio got=%0d exp=1", fwd_sel[1:0]); end
        e_valid = 0;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd2) begin failures++; $display("FAIL fwd_m got=%0d exp=2", fwd_sel[1:0]); end
        e_valid = 1; e_rd = 6'd0; m_rd = 6'd0; d_rs[0 +: 6] = 6'd0;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd0) begin failures++; $display("FAIL fwd_r0 got=%0d exp=0", fwd_sel[1:0]); end
        // src2 matches M only; src1 matches E but is not used.
        e_rd = 6'd9; m_rd = 6'd17;
        d_rs[6 +: 6] = 6'd9; d_rs[12 +: 6] = 6'd17; d_rs_used = 3'b100;
        #1;
        checks++; if (fwd_sel !== 6'b10_00_00) begin failures++; $display("FAIL fwd_src2_m got=%0h exp=20", fwd_sel); end
        $display("test_forwarding: done");
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_idle();
        d_rs[6 +: 6] = 6'd7; d_rs_used = 3'b010;
        e_valid = 1; e_regwrite = 1; e_memread = 1; e_rd = 6'd7;
        #1;
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall_d); end
        checks++; if (exec_flush !== 1'b1) begin failures++; $display("FAIL lu_exec_flush got=%0b exp=1", exec_flush); end
        checks++; if ({fetch_en, decode_en, exec_en} !== 3'b000) begin failures++; $display("FAIL lu_enables got=%b exp=000", {fetch_en, decode_en, exec_en}); end
        checks++; if (memory_en !== 1'b1) begin failures++; $display("FAIL lu_memory_en got=%0b exp=1", memory_en); end
        checks++; if (fwd_sel[3:2] !== 2'd0) begin failures++; $display("FAIL lu_no_fwd got=%0d exp=0", fwd_sel[3:2]); end
        d_rs_used = 3'b000;
        #1;
        checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL lu_unused_stall got=%0b exp=0", stall_d); end
        checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL lu_unused_fetch got=%0b exp=1", fetch_en); end
        // Back stage busy: nothing advances, no bubble.
        d_rs_used = 3'b010; exec_fin = 0;
        #1;
        checks++; if ({memory_en, exec_flush, write_en} !== 3'b001) begin failures++; $display("FAIL go_low got=%b exp=001", {memory_en, exec_flush, write_en}); end
        memory_fin = 0;
        #1;
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL write_en_low got=%0b exp=0", write_en); end
        $display("test_load_use: done");
    endtask

    task automatic test_scoreboard();
        do_reset();
        @(negedge clk);
        set_idle();
        drive_long(6'd40);
        #1;
        checks++; if (stall_d !== 1'b0 || exec_en !== 1'b1) begin failures++; $display("FAIL sb_issue got=%b exp=01", {stall_d, exec_en}); end
        @(negedge clk);
        set_idle();
        d_valid = 1; d_rs[0 +: 6] = 6'd40; d_rs_used = 3'b001;
        #1;
        checks++; if (sb_busy[40] !== 1'b1) begin failures++; $display("FAIL sb_busy40 got=%0b exp=1", sb_busy[40]); end
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL sb_raw_stall got=%0b exp=1", stall_d); end
        @(negedge clk);
        lw_done = 1; lw_rd = 6'd40;
        #1;
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL sb_done_cycle got=%0b exp=1", stall_d); end
        @(negedge clk);
        lw_done = 0;
        #1;
        checks++; if (sb_busy[40] !== 1'b0) begin failures++; $display("FAIL sb_clear got=%0b exp=0", sb_busy[40]); end
        checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL sb_release got=%0b exp=0", stall_d); end
        checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
        $display("test_scoreboard: done");
    endtask

    task automatic test_capacity();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_idle();
            drive_long(6'(10 + i));
            #1;
            checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL cap_issue%0d got=%0b exp=0", i, stall_d); end
        end
        @(negedge clk);
        drive_long(6'd14);
        #1;
        checks++; if (sb_busy[13:10] !== 4'hF) begin failures++; $display("FAIL cap_busy got=%0h exp=f", sb_busy[13:10]); end
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL cap_full got=%0b exp=1", stall_d); end
        // Done and re-issue to the same reg.
        @(negedge clk);
        drive_long(6'd12); lw_done = 1; lw_rd = 6'd12;
        #1;
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL waw_stall got=%0b exp=1", stall_d); end
        @(negedge clk);
        lw_done = 0;
        #1;
        checks++; if (sb_busy[12] !== 1'b0 || stall_d !== 1'b0) begin failures++; $display("FAIL waw_release got=%b exp=00", {sb_busy[12], stall_d}); end
        @(negedge clk);
        drive_long(6'd14);
        #1;
        checks++; if (sb_busy[12] !== 1'b1 || stall_d !== 1'b1) begin failures++; $display("FAIL refull got=%b exp=11", {sb_busy[12], stall_d}); end
        // Write-back to a non-busy reg must not free a slot.
        @(negedge clk);
        set_idle(); lw_done = 1; lw_rd = 6'd30;
        @(negedge clk);
        set_idle();
        drive_long(6'd14);
        #1;
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL stale_done got=%0b exp=1", stall_d); end
        // Drop to 3, then issue 14 while 11 retires in the same cycle.
        @(negedge clk);
        set_idle(); lw_done = 1; lw_rd = 6'd10;
        @(negedge clk);
        set_idle();
        drive_long(6'd14); lw_done = 1; lw_rd = 6'd11;
        #1;
        checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL mixed_issue got=%0b exp=0", stall_d); end
        @(negedge clk);
        set_idle();
        drive_long(6'd15);
        #1;
        checks++; if (sb_busy[15:10] !== 6'b011100) begin failures++; $display("FAIL mixed_busy got=%b exp=011100", sb_busy[15:10]); end
        checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL mixed_room got=%0b exp=0", stall_d); end
        @(negedge clk);
        drive_long(6'd16);
        #1;
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL mixed_full got=%0b exp=1", stall_d); end
        $display("test_capacity: done");
    endtask

    task automatic test_mispredict();
        do_reset();
        @(negedge clk);
        set_idle();
        drive_long(6'd50); branchjump_miss = 1;
        #1;
        checks++; if ({decode_flush, exec_flush} !== 2'b11) begin failures++; $display("FAIL bjm_flush got=%b exp=11", {decode_flush, exec_flush}); end
        checks++; if ({fetch_en, exec_en, memory_en} !== 3'b001) begin failures++; $display("FAIL bjm_enables got=%b exp=001", {fetch_en, exec_en, memory_en}); end
        @(negedge clk);
        set_idle();
        drive_long(6'd33);
        #1;
        checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (sb_busy[50] !== 1'b0) begin failures++; $display("FAIL bjm_no_issue got=%0b exp=0", sb_busy[50]); end
        @(negedge clk);
        set_idle();
        #1;
        checks++; if (sb_busy[33] !== 1'b1) begin failures++; $display("FAIL pre_rst_busy got=%0b exp=1", sb_busy[33]); end
        #1;
        rstn = 0;
        #1;
        checks++; if (sb_busy !== '0 || flush_cnt !== '0 || stall_cnt !== '0) begin failures++; $display("FAIL async_rst got=%0h/%0d/%0d exp=0/0/0", sb_busy, flush_cnt, stall_cnt); end
        @(negedge clk);
        rstn = 1; lw_done = 1; lw_rd = 6'd33;
        @(negedge clk);
        set_idle();
        drive_long(6'd34);
        #1;
        checks++; if (sb_busy !== '0 || stall_d !== 1'b0) begin failures++; $display("FAIL post_rst got=%0h/%0b exp=0/0", sb_busy, stall_d); end
        $display("test_mispredict: done");
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_scoreboard();
        test_capacity();
        test_mispredict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
